uart_cmd_system: RTL and testbench
==================================

Name: uart_cmd_system

Overview:
- Single-clock UART command processor. It receives 8-bit command frames on RX_IN and decodes a 4-command protocol.
- Commands operate on a 16x8 register file and an 8-bit ALU. Read and ALU results are returned as UART frames on TX_OUT.
- Top of the UART subsystem; RX, command FSM, register file, ALU and TX all run in one clock domain.

Parameters:
- PRESCALE, 32, UART_CLK cycles per serial bit (even, >=8).
- PAR_EN, 1, 1 = frame carries a parity bit.
- PAR_TYP, 0, 0 = even parity, 1 = odd parity.

Ports:
- UART_CLK  input  1  sole clock, rising edge.
- RST  input  1  asynchronous active-low reset.
- RX_IN  input  1  serial in, idles high.
- TX_OUT  output  1  serial out, idles high.
- Par_Err  output  1  parity error of the last received frame.
- Stp_Err  output  1  stop-bit error of the last received frame.

Behaviour:
- Reset (RST=0, async): all state cleared; TX_OUT=1, Par_Err=0, Stp_Err=0; all registers=0; command FSM in IDLE. Reset mid-frame aborts RX and TX.
- Frame format, LSB first: start(0), D0..D7, parity (only if PAR_EN), stop(1). Each bit is PRESCALE cycles long.
- RX start detection: a falling edge on RX_IN while idle starts a bit counter.
- RX sampling: each bit is sampled at cycle PRESCALE/2 of the bit, as a single sample.
- RX false start: if the start-bit sample is 1, RX returns to idle with no flags changed.
- RX frame completion: at the stop-bit sample, Par_Err and Stp_Err are updated, and a data_valid pulse (1 cycle) is emitted only if both flags are 0.
- Error flags: Par_Err=1 if the received parity mismatches the computed parity (PAR_EN=1 only); Stp_Err=1 if the stop sample is 0. Both flags hold until the next frame's stop sample.
- After the stop sample, RX can accept a new start edge immediately.
- Command FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FN. Each valid byte advances the state.
- 0xAA (write): IDLE->WR_ADDR (latch addr[3:0]) ->WR_DATA (reg[addr]=byte) ->IDLE. No response.
- 0xBB (read): IDLE->RD_ADDR; the byte's [3:0] selects the register; reg[addr] is sent on TX; ->IDLE.
- 0xCC (ALU with operands): IDLE->ALU_A (reg[0]=byte) ->ALU_B (reg[1]=byte) ->ALU_FN.
- 0xDD (ALU on stored operands): IDLE->ALU_FN directly.
- ALU_FN: the byte's [3:0] selects the function on A=reg[0], B=reg[1]. The 8-bit result is sent on TX; ->IDLE.
- Unknown command bytes in IDLE are ignored. Frames with errors are discarded and do not advance the FSM.
- ALU functions, 8-bit results with carry/overflow dropped:
  - 0 ADD A+B; 1 SUB A-B (mod 256); 2 MUL low byte of A*B;
  - 3 AND; 4 OR; 5 XOR;
  - 6 SHR A>>1 (zero fill); 7 SHL A<<1 (zero fill);
  - 8-15 -> 0x00.
- TX: a response byte is loaded into a 1-entry pending register in the cycle after the triggering data_valid. The TX start bit begins 2 cycles after the stop-bit sample when TX is idle.
- TX transmission: the frame is sent with the same format, PRESCALE cycles per bit. After the stop bit, TX_OUT stays 1.
- TX busy: if TX is busy, the pending byte waits. A new response arriving while pending is still full is dropped; this is unreachable at protocol rates.

Test Plan:
- Reset: hold RST=0 -> TX_OUT=1, Par_Err=0, Stp_Err=0; release with RX_IN=1 -> no TX activity.
- Write/read: AA, 02, 5A then BB, 02 -> TX frame data 0x5A, parity 0, stop 1; Par_Err=Stp_Err=0 throughout.
- ALU with operands: CC, 0C, 03, 00 -> TX 0x0F. Then DD, 01 -> TX 0x09.
- Shifts: DD, 06 -> TX 0x06. DD, 07 -> TX 0x18.
- Parity error: frame with 0x5A and parity bit 1 -> Par_Err=1 at stop sample; FSM state unchanged; no TX. Next good frame clears Par_Err.
- Stop error and false start:
  - Stop bit 0 -> Stp_Err=1, frame discarded.
  - A 4-cycle low glitch on RX_IN -> no frame, flags unchanged.
  - RST asserted mid-TX -> TX_OUT=1 immediately.

Source files
------------

// File: rtl/uart_cmd_system.sv
// uart_cmd_system
//   Single-clock UART command processor. Received bytes drive a small
//   command FSM that writes/reads a 16x8 register file and runs an 8-bit
//   ALU on reg[0]/reg[1]; read and ALU results go back out on TX_OUT.
//   Commands: 0xAA addr data (write), 0xBB addr (read),
//             0xCC a b fn (load operands + ALU), 0xDD fn (ALU on stored).
// Ports
//   UART_CLK : clock, rising edge
//   RST      : asynchronous active-low reset
//   RX_IN    : serial input, idles high
//   TX_OUT   : serial output, idles high
//   Par_Err  : parity error of the last received frame
//   Stp_Err  : stop-bit error of the last received frame
module uart_cmd_system #(
    parameter int unsigned PRESCALE = 32,
    parameter bit          PAR_EN   = 1'b1,
    parameter bit          PAR_TYP  = 1'b0
) (
    input  logic UART_CLK,
    input  logic RST,
    input  logic RX_IN,
    output logic TX_OUT,
    output logic Par_Err,
    output logic Stp_Err
);

    localparam int unsigned   NBITS    = PAR_EN ? 11 : 10;
    localparam int unsigned   CW       = $clog2(PRESCALE);
    localparam logic [CW-1:0] HALF     = CW'(PRESCALE / 2);
    localparam logic [CW-1:0] LASTC    = CW'(PRESCALE - 1);
    localparam logic [3:0]    LAST_BIT = 4'(NBITS - 1);
    localparam logic [3:0]    PAR_BIT  = 4'd9;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_ADDR = 3'd1;
    localparam logic [2:0] ST_WR_DATA = 3'd2;
    localparam logic [2:0] ST_RD_ADDR = 3'd3;
    localparam logic [2:0] ST_ALU_A   = 3'd4;
    localparam logic [2:0] ST_ALU_B   = 3'd5;
    localparam logic [2:0] ST_ALU_FN  = 3'd6;

    // ---------------- receiver ----------------
    logic          rx_prev, rx_busy, rx_par, data_valid;
    logic [CW-1:0] rx_cnt;
    logic [3:0]    rx_idx;
    logic [7:0]    rx_data;
    logic          par_bad;

    assign par_bad = PAR_EN && (rx_par != ((^rx_data) ^ PAR_TYP));

    // Bit index 0 is the start bit; the edge-detect cycle counts as cycle 0
    // of that bit, so every bit is sampled exactly PRESCALE/2 cycles in.
    always_ff @(posedge UART_CLK or negedge RST) begin
        if (!RST) begin
            rx_prev    <= 1'b1;
            rx_busy    <= 1'b0;
            rx_par     <= 1'b0;
            rx_cnt     <= '0;
            rx_idx     <= '0;
            rx_data    <= '0;
            data_valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stp_Err    <= 1'b0;
        end else begin
            rx_prev    <= RX_IN;
            data_valid <= 1'b0;
            if (!rx_busy) begin
                if (rx_prev && !RX_IN) begin
                    rx_busy <= 1'b1;
                    rx_cnt  <= CW'(1);
                    rx_idx  <= '0;
                end
            end else begin
                if (rx_cnt == LASTC) begin
                    rx_cnt <= '0;
                    rx_idx <= rx_idx + 4'd1;
                end else begin
                    rx_cnt <= rx_cnt + CW'(1);
                end
                if (rx_cnt == HALF) begin
                    if (rx_idx == 4'd0) begin
                        if (RX_IN) rx_busy <= 1'b0;
                    end else if (rx_idx == LAST_BIT) begin
                        rx_busy    <= 1'b0;
                        Par_Err    <= par_bad;
                        Stp_Err    <= !RX_IN;
                        data_valid <= !par_bad && RX_IN;
                    end else if (PAR_EN && rx_idx == PAR_BIT) begin
                        rx_par <= RX_IN;
                    end else begin
                        rx_data <= {RX_IN, rx_data[7:1]};
                    end
                end
            end
        end
    end

    // ---------------- command FSM, register file, ALU ----------------
    logic [2:0] state;
    logic [3:0] wr_addr;
    logic [7:0] regs [16];
    logic [7:0] alu_res;
    logic [15:0] prod;
    logic       resp_valid;
    logic [7:0] resp_data;

    assign prod = regs[0] * regs[1];

    always_comb begin
        alu_res = '0;
        case (rx_data[3:0])
            4'd0:    alu_res = regs[0] + regs[1];
            4'd1:    alu_res = regs[0] - regs[1];
            4'd2:    alu_res = prod[7:0];
            4'd3:    alu_res = regs[0] & regs[1];
            4'd4:    alu_res = regs[0] | regs[1];
            4'd5:    alu_res = regs[0] ^ regs[1];
            4'd6:    alu_res = {1'b0, regs[0][7:1]};
            4'd7:    alu_res = {regs[0][6:0], 1'b0};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        resp_valid = 1'b0;
        resp_data  = '0;
        if (data_valid) begin
            if (state == ST_RD_ADDR) begin
                resp_valid = 1'b1;
                resp_data  = regs[rx_data[3:0]];
            end else if (state == ST_ALU_FN) begin
                resp_valid = 1'b1;
                resp_data  = alu_res;
            end
        end
    end

    always_ff @(posedge UART_CLK or negedge RST) begin
        if (!RST) begin
            state   <= ST_IDLE;
            wr_addr <= '0;
            for (int unsigned i = 0; i < 16; i++) regs[i] <= '0;
        end else if (data_valid) begin
            case (state)
                ST_IDLE: begin
                    case (rx_data)
                        8'hAA:   state <= ST_WR_ADDR;
                        8'hBB:   state <= ST_RD_ADDR;
                        8'hCC:   state <= ST_ALU_A;
                        8'hDD:   state <= ST_ALU_FN;
                        default: state <= ST_IDLE;
                    endcase
                end
                ST_WR_ADDR: begin
                    wr_addr <= rx_data[3:0];
                    state   <= ST_WR_DATA;
                end
                ST_WR_DATA: begin
                    regs[wr_addr] <= rx_data;
                    state         <= ST_IDLE;
                end
                ST_ALU_A: begin
                    regs[0] <= rx_data;
                    state   <= ST_ALU_B;
                end
                ST_ALU_B: begin
                    regs[1] <= rx_data;
                    state   <= ST_ALU_FN;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // ---------------- pending response + transmitter ----------------
    logic          pend_full, tx_busy, tx_load;
    logic [7:0]    pend_data;
    logic [10:0]   tx_frame;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_idx;

    assign tx_load = pend_full && !tx_busy;

    // A hand-off to TX in the same cycle frees the slot for a new response.
    always_ff @(posedge UART_CLK or negedge RST) begin
        if (!RST) begin
            pend_full <= 1'b0;
            pend_data <= '0;
        end else begin
            if (tx_load) pend_full <= 1'b0;
            if (resp_valid && (!pend_full || tx_load)) begin
                pend_full <= 1'b1;
                pend_data <= resp_data;
            end
        end
    end

    always_ff @(posedge UART_CLK or negedge RST) begin
        if (!RST) begin
            TX_OUT   <= 1'b1;
            tx_busy  <= 1'b0;
            tx_frame <= '1;
            tx_cnt   <= '0;
            tx_idx   <= '0;
        end else if (tx_load) begin
            tx_busy  <= 1'b1;
            tx_frame <= {1'b1, PAR_EN ? ((^pend_data) ^ PAR_TYP) : 1'b1, pend_data, 1'b0};
            TX_OUT   <= 1'b0;
            tx_cnt   <= '0;
            tx_idx   <= '0;
        end else if (tx_busy) begin
            if (tx_cnt == LASTC) begin
                tx_cnt <= '0;
                if (tx_idx == LAST_BIT) begin
                    tx_busy <= 1'b0;
                    TX_OUT  <= 1'b1;
                end else begin
                    tx_idx <= tx_idx + 4'd1;
                    TX_OUT <= tx_frame[tx_idx + 4'd1];
                end
            end else begin
                tx_cnt <= tx_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_system.sv
module tb_uart_cmd_system;

    localparam int unsigned P = 32;

    logic UART_CLK = 1'b0;
    logic RST;
    logic RX_IN;
    logic TX_OUT;
    logic Par_Err;
    logic Stp_Err;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    always #5 UART_CLK = ~UART_CLK;

    uart_cmd_system #(
        .PRESCALE (P),
        .PAR_EN   (1'b1),
        .PAR_TYP  (1'b0)
    ) dut (
        .UART_CLK (UART_CLK),
        .RST      (RST),
        .RX_IN    (RX_IN),
        .TX_OUT   (TX_OUT),
        .Par_Err  (Par_Err),
        .Stp_Err  (Stp_Err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one frame: even parity unless par_flip, chosen stop bit value.
    task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop);
        logic [10:0] bits;
        bits = {stop, (^d) ^ par_flip, d, 1'b0};
        @(posedge UART_CLK); #1;
        for (int i = 0; i < 11; i++) begin
            RX_IN = bits[i];
            repeat (P) @(posedge UART_CLK);
            #1;
        end
        RX_IN = 1'b1;
    endtask

    task automatic send(input logic [7:0] d);
        send_frame(d, 1'b0, 1'b1);
    endtask

    // Capture one TX frame (bounded wait for start) and check all fields.
    task automatic expect_tx(input string tag, input logic [7:0] exp);
        logic [10:0] f;
        logic seen;
        seen = 1'b0;
        f = '0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge UART_CLK);
            if (TX_OUT === 1'b0) seen = 1'b1;
        end
        check_eq({tag, "_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            repeat (P / 2) @(negedge UART_CLK);
            f[0] = TX_OUT;
            for (int b = 1; b < 11; b++) begin
                repeat (P) @(negedge UART_CLK);
                f[b] = TX_OUT;
            end
            check_eq({tag, "_start"},  32'(f[0]),   32'd0);
            check_eq({tag, "_data"},   32'(f[8:1]), 32'(exp));
            check_eq({tag, "_parity"}, 32'(f[9]),   32'(^exp));
            check_eq({tag, "_stop"},   32'(f[10]),  32'd1);
        end
    endtask

    task automatic watch_idle(input string tag, input int unsigned n);
        int unsigned lows;
        lows = 0;
        repeat (n) begin
            @(negedge UART_CLK);
            if (TX_OUT !== 1'b1) lows++;
        end
        check_eq(tag, lows, 32'd0);
    endtask

    task automatic alu_stored(input string tag, input logic [3:0] fn, input logic [7:0] exp);
        send(8'hDD);
        fork
            send({4'h0, fn});
            expect_tx(tag, exp);
        join
    endtask

    initial begin
        RX_IN = 1'b1;
        RST   = 1'b0;
        repeat (5) @(posedge UART_CLK);
        #1;
        check_eq("rst_tx",  32'(TX_OUT),  32'd1);
        check_eq("rst_par", 32'(Par_Err), 32'd0);
        check_eq("rst_stp", 32'(Stp_Err), 32'd0);
        RST = 1'b1;
        watch_idle("idle_after_rst", 200);

        // write 0x5A to reg 2, read it back
        send(8'hAA); send(8'h02); send(8'h5A);
        send(8'hBB);
        fork
            send(8'h02);
            expect_tx("rd_r2", 8'h5A);
        join
        check_eq("wr_rd_par", 32'(Par_Err), 32'd0);
        check_eq("wr_rd_stp", 32'(Stp_Err), 32'd0);

        // ALU with operands A=0x0C B=0x03
        send(8'hCC); send(8'h0C); send(8'h03);
        fork
            send(8'h00);
            expect_tx("alu_add", 8'h0F);
        join
        alu_stored("alu_sub", 4'd1, 8'h09);
        alu_stored("alu_mul", 4'd2, 8'h24);
        alu_stored("alu_shr", 4'd6, 8'h06);
        alu_stored("alu_shl", 4'd7, 8'h18);
        alu_stored("alu_xor", 4'd5, 8'h0F);
        alu_stored("alu_fn9", 4'd9, 8'h00);

        // parity error while waiting for a read address
        send(8'hBB);
        fork
            send_frame(8'h5A, 1'b1, 1'b1);
            watch_idle("par_no_tx", 400);
        join
        check_eq("par_err_set", 32'(Par_Err), 32'd1);
        check_eq("par_stp_clr", 32'(Stp_Err), 32'd0);
        fork
            send(8'h02);
            expect_tx("rd_after_par", 8'h5A);
        join
        check_eq("par_err_clr", 32'(Par_Err), 32'd0);

        // stop error on a read command: must be discarded
        fork
            send_frame(8'hBB, 1'b0, 1'b0);
            watch_idle("stp_no_tx", 400);
        join
        check_eq("stp_err_set", 32'(Stp_Err), 32'd1);
        check_eq("stp_par_clr", 32'(Par_Err), 32'd0);

        // 4-cycle glitch: false start, flags hold
        @(posedge UART_CLK); #1;
        RX_IN = 1'b0;
        repeat (4) @(posedge UART_CLK);
        #1;
        RX_IN = 1'b1;
        watch_idle("glitch_no_tx", 100);
        check_eq("glitch_stp_hold", 32'(Stp_Err), 32'd1);
        check_eq("glitch_par_hold", 32'(Par_Err), 32'd0);

        // 0x02 in IDLE is unknown -> ignored (proves BB was discarded)
        fork
            send(8'h02);
            watch_idle("unknown_no_tx", 400);
        join
        check_eq("stp_err_clr", 32'(Stp_Err), 32'd0);
        alu_stored("alu_or", 4'd4, 8'h0F);

        // reset in the middle of a TX frame
        send(8'hBB);
        fork
            send(8'h02);
            begin
                logic seen;
                seen = 1'b0;
                for (int i = 0; i < 3000 && !seen; i++) begin
                    @(negedge UART_CLK);
                    if (TX_OUT === 1'b0) seen = 1'b1;
                end
                check_eq("midtx_seen", 32'(seen), 32'd1);
                repeat (5) @(negedge UART_CLK);
                check_eq("midtx_low", 32'(TX_OUT), 32'd0);
                RST = 1'b0;
                #1;
                check_eq("midtx_rst_tx", 32'(TX_OUT), 32'd1);
            end
        join
        check_eq("midtx_rst_par", 32'(Par_Err), 32'd0);
        check_eq("midtx_rst_stp", 32'(Stp_Err), 32'd0);
        @(posedge UART_CLK); #1;
        RST = 1'b1;
        repeat (5) @(posedge UART_CLK);
        send(8'hBB);
        fork
            send(8'h02);
            expect_tx("rd_after_rst", 8'h00);
        join

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
